// File: rtl/gshare_bht.sv
// +--------------------------------------------------------------------------+
// | Module   : gshare_bht                                                    |
// | Purpose  : Gshare branch history table. Per-fetch-slot saturating        |
// |            counters indexed by PC row XOR global history, with a         |
// |            row-by-row clearing engine after reset or flush.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module gshare_bht #(
  parameter int unsigned NR_ENTRIES      = 1024,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned COUNTER_BITS    = 2,
  parameter int unsigned HISTORY_BITS    = 8,
  parameter int unsigned VLEN            = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       debug_mode_i,
  input  logic [VLEN-1:0]            vpc_i,
  input  logic                       update_valid_i,
  input  logic [VLEN-1:0]            update_pc_i,
  input  logic                       update_taken_i,
  input  logic [HISTORY_BITS-1:0]    update_ghr_i,
  output logic [HISTORY_BITS-1:0]    ghr_o,
  output logic                       busy_o,
  output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] pred_taken_o
);

  // Address field geometry: bit 0 of the PC is ignored (compressed-instruction
  // granularity), then the column inside a fetch row, then the row index.
  localparam int unsigned c_OFFSET   = 1;
  localparam int unsigned c_NR_ROWS  = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned c_ROW_BITS = $clog2(c_NR_ROWS);
  localparam int unsigned c_COL_BITS = $clog2(INSTR_PER_FETCH);
  localparam int unsigned c_COL_W    = (c_COL_BITS > 0) ? c_COL_BITS : 1;
  localparam int unsigned c_ROW_LSB  = c_COL_BITS + c_OFFSET;

  // Counter limits; cleared entries sit at weakly-not-taken.
  localparam logic [COUNTER_BITS-1:0] c_CNT_MAX  = '1;
  localparam logic [COUNTER_BITS-1:0] c_CNT_INIT = {1'b0, {(COUNTER_BITS-1){1'b1}}};
  localparam logic [c_ROW_BITS-1:0]   c_LAST_ROW = c_ROW_BITS'(c_NR_ROWS - 1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e                    r_state;
  logic [c_ROW_BITS-1:0]     r_row_cnt;
  logic [HISTORY_BITS-1:0]   r_ghr;

  // Table storage: one valid bit and one counter per slot per row.
  logic                      r_valid [c_NR_ROWS][INSTR_PER_FETCH];
  logic [COUNTER_BITS-1:0]   r_cnt   [c_NR_ROWS][INSTR_PER_FETCH];

  logic [c_ROW_BITS-1:0]     w_pred_row;
  logic [c_ROW_BITS-1:0]     w_upd_row;
  logic [c_COL_W-1:0]        w_upd_col;
  logic                      w_upd_accept;
  logic                      w_busy;
  logic [HISTORY_BITS-1:0]   w_ghr_next;
  logic [COUNTER_BITS-1:0]   w_upd_cnt_old;
  logic [COUNTER_BITS-1:0]   w_upd_cnt_next;
  logic                      w_unused_pc;

  // Only the index fields of the PCs matter; fold the rest away.
  assign w_unused_pc = ^{vpc_i, update_pc_i};

  assign w_busy = (r_state == S_CLEAR);
  assign busy_o = w_busy;
  assign ghr_o  = r_ghr;

  // Row indices: PC row field XOR zero-extended history.
  assign w_pred_row = vpc_i[c_ROW_LSB +: c_ROW_BITS] ^ c_ROW_BITS'(r_ghr);
  assign w_upd_row  = update_pc_i[c_ROW_LSB +: c_ROW_BITS] ^ c_ROW_BITS'(update_ghr_i);

  generate
    if (c_COL_BITS > 0) begin : g_col_idx
      assign w_upd_col = update_pc_i[c_OFFSET +: c_COL_BITS];
    end else begin : g_col_none
      assign w_upd_col = '0;
    end
  endgenerate

  // History shift register input; a one-bit history just holds the last outcome.
  generate
    if (HISTORY_BITS > 1) begin : g_ghr_wide
      assign w_ghr_next = {r_ghr[HISTORY_BITS-2:0], update_taken_i};
    end else begin : g_ghr_single
      assign w_ghr_next = update_taken_i;
    end
  endgenerate

  // Updates are only taken while ready, outside debug, and never in a flush or reset cycle.
  assign w_upd_accept = update_valid_i && !debug_mode_i && !flush_i && !rst_i
                        && (r_state == S_READY);

  // Saturating increment/decrement of the addressed counter.
  always_comb begin
    w_upd_cnt_old  = r_cnt[w_upd_row][w_upd_col];
    w_upd_cnt_next = w_upd_cnt_old;
    if (update_taken_i) begin
      if (w_upd_cnt_old != c_CNT_MAX) begin
        w_upd_cnt_next = w_upd_cnt_old + COUNTER_BITS'(1);
      end
    end else begin
      if (w_upd_cnt_old != '0) begin
        w_upd_cnt_next = w_upd_cnt_old - COUNTER_BITS'(1);
      end
    end
  end

  // Clear/ready control: row walker, state and global history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_CLEAR;
      r_row_cnt <= '0;
      r_ghr     <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (flush_i) begin
            r_row_cnt <= '0;
            r_ghr     <= '0;
          end else if (r_row_cnt == c_LAST_ROW) begin
            r_row_cnt <= '0;
            r_state   <= S_READY;
          end else begin
            r_row_cnt <= r_row_cnt + c_ROW_BITS'(1);
          end
        end
        S_READY: begin
          if (flush_i) begin
            r_state   <= S_CLEAR;
            r_row_cnt <= '0;
            r_ghr     <= '0;
          end else if (w_upd_accept) begin
            r_ghr <= w_ghr_next;
          end
        end
        default: begin
          r_state   <= S_CLEAR;
          r_row_cnt <= '0;
          r_ghr     <= '0;
        end
      endcase
    end
  end

  // Table writes: one full row per cycle while clearing, else the resolved-branch update.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (r_state == S_CLEAR) begin
        for (int c = 0; c < int'(INSTR_PER_FETCH); c++) begin
          r_valid[r_row_cnt][c] <= 1'b0;
          r_cnt[r_row_cnt][c]   <= c_CNT_INIT;
        end
      end else if (w_upd_accept) begin
        r_valid[w_upd_row][w_upd_col] <= 1'b1;
        r_cnt[w_upd_row][w_upd_col]   <= w_upd_cnt_next;
      end
    end
  end

  // Per-slot predictions, gated off while the table is being cleared.
  generate
    for (genvar i = 0; i < int'(INSTR_PER_FETCH); i++) begin : g_slot
      assign pred_valid_o[i] = !w_busy && r_valid[w_pred_row][i];
      assign pred_taken_o[i] = !w_busy && r_cnt[w_pred_row][i][COUNTER_BITS-1];
    end
  endgenerate

endmodule

`default_nettype wire
